// File: rtl/ma_mem_unit.sv
`default_nettype none
// ============================================================================
//  Module   : ma_mem_unit
//  Brief    : Memory-access stage with a word-organised byte-lane data memory,
//             a valid/ready request handshake, WAIT_STATES extra access cycles
//             and an error flag. Optional macro: MA_MISALIGN_TRAP_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module ma_mem_unit #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            memR,
    input  logic            memW,
    input  logic [2:0]      mem_ctrl,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] dataW,
    output logic            resp_valid,
    output logic [XLEN-1:0] dataR,
    output logic            err
);

    localparam int         c_AW      = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_WS_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam logic       c_NO_WAIT = (WAIT_STATES == 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [3:0]      r_cnt;
    logic [3:0]      w_cnt_next;

    logic            r_memR;
    logic            r_memW;
    logic [2:0]      r_ctrl;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_dataW;
    logic [XLEN-1:0] r_dataR;
    logic            r_err;

    logic [XLEN-1:0] r_mem [DEPTH_WORDS];

    logic            w_accept;
    logic            w_enter_resp;
    logic            w_cur_memR;
    logic            w_cur_memW;
    logic [2:0]      w_cur_ctrl;
    logic [XLEN-1:0] w_cur_addr;
    logic [XLEN-1:0] w_cur_dataW;
    logic [1:0]      w_size;
    logic            w_bad_ctrl;
    logic            w_illegal;
    logic            w_trap;
    logic            w_err;
    logic            w_do_write;
    logic            w_do_read;
    logic [1:0]      w_lane;
    logic [4:0]      w_shamt;
    logic [c_AW-1:0] w_idx;
    logic [XLEN-1:0] w_rword;
    logic [XLEN-1:0] w_rshift;
    logic [XLEN-1:0] w_load_val;
    logic [XLEN-1:0] w_mask_base;
    logic [XLEN-1:0] w_wmask;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_wword;
    logic            w_unused_addr_hi;

    assign w_accept = req_valid && (r_state == S_IDLE);

    // In IDLE the request is decoded straight from the ports so a zero-wait
    // or trapped access can complete on the accept edge itself.
    assign w_cur_memR  = (r_state == S_IDLE) ? memR     : r_memR;
    assign w_cur_memW  = (r_state == S_IDLE) ? memW     : r_memW;
    assign w_cur_ctrl  = (r_state == S_IDLE) ? mem_ctrl : r_ctrl;
    assign w_cur_addr  = (r_state == S_IDLE) ? addr     : r_addr;
    assign w_cur_dataW = (r_state == S_IDLE) ? dataW    : r_dataW;

    assign w_size     = w_cur_ctrl[1:0];
    assign w_bad_ctrl = (w_cur_ctrl[1] & w_cur_ctrl[0]) | (w_cur_ctrl[2] & w_cur_ctrl[1]);
    assign w_illegal  = (w_cur_memR & w_cur_memW) | w_bad_ctrl | (w_cur_memW & w_cur_ctrl[2]);

`ifdef MA_MISALIGN_TRAP_EN
    logic w_misaligned;
    assign w_misaligned = (w_cur_memR | w_cur_memW) &
                          (((w_size == 2'b01) & w_cur_addr[0]) |
                           ((w_size == 2'b10) & (w_cur_addr[1:0] != 2'b00)));
    assign w_trap = w_misaligned & ~w_illegal;
    assign w_lane = w_cur_addr[1:0];
`else
    assign w_trap = 1'b0;
    assign w_lane = (w_size == 2'b01) ? {w_cur_addr[1], 1'b0} :
                    (w_size == 2'b10) ? 2'b00 : w_cur_addr[1:0];
`endif

    assign w_err      = w_illegal | w_trap;
    assign w_do_write = w_cur_memW & ~w_err;
    assign w_do_read  = w_cur_memR & ~w_err;

    assign w_idx            = w_cur_addr[c_AW+1:2];
    assign w_unused_addr_hi = ^w_cur_addr[XLEN-1:c_AW+2];
    assign w_shamt          = {w_lane, 3'b000};
    assign w_rword          = r_mem[w_idx];
    assign w_rshift         = w_rword >> w_shamt;

    always_comb begin
        w_load_val  = w_rshift;
        w_mask_base = '1;
        case (w_size)
            2'b00: begin
                w_load_val  = {{(XLEN-8){~w_cur_ctrl[2] & w_rshift[7]}}, w_rshift[7:0]};
                w_mask_base = XLEN'(8'hFF);
            end
            2'b01: begin
                w_load_val  = {{(XLEN-16){~w_cur_ctrl[2] & w_rshift[15]}}, w_rshift[15:0]};
                w_mask_base = XLEN'(16'hFFFF);
            end
            default: begin
                w_load_val  = w_rshift;
                w_mask_base = '1;
            end
        endcase
    end

    assign w_wmask = w_mask_base << w_shamt;
    assign w_wdata = (w_cur_dataW & w_mask_base) << w_shamt;
    assign w_wword = (w_rword & ~w_wmask) | (w_wdata & w_wmask);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (c_NO_WAIT || w_trap) begin
                        w_state_next = S_RESP;
                    end else begin
                        w_state_next = S_WAIT;
                        w_cnt_next   = c_WS_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_enter_resp = (w_state_next == S_RESP) && (r_state != S_RESP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_dataR <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_dataR <= (w_enter_resp && w_do_read) ? w_load_val : '0;
            r_err   <= w_enter_resp && w_err;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_memR  <= 1'b0;
            r_memW  <= 1'b0;
            r_ctrl  <= 3'd0;
            r_addr  <= '0;
            r_dataW <= '0;
        end else if (w_accept) begin
            r_memR  <= memR;
            r_memW  <= memW;
            r_ctrl  <= mem_ctrl;
            r_addr  <= addr;
            r_dataW <= dataW;
        end
    end

    // Gated by rst_n so a reset landing on the commit edge drops the store.
    always_ff @(posedge clk) begin
        if (rst_n && w_enter_resp && w_do_write) begin
            r_mem[w_idx] <= w_wword;
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign dataR      = r_dataR;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ma_mem_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ma_mem_unit
//  Brief    : Self-checking bench for ma_mem_unit against a byte-array model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ma_mem_unit;

    localparam int XLEN        = 32;
    localparam int DEPTH_WORDS = 1024;
    localparam int WAIT_STATES = 2;
    localparam int NBYTES      = DEPTH_WORDS * 4;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        req_valid = 1'b0;
    logic        memR      = 1'b0;
    logic        memW      = 1'b0;
    logic [2:0]  mem_ctrl  = 3'd0;
    logic [31:0] addr      = 32'd0;
    logic [31:0] dataW     = 32'd0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] dataR;
    logic        err;

    int checks = 0;
    int errors = 0;

    byte unsigned model [NBYTES];

    ma_mem_unit #(
        .XLEN       (XLEN),
        .DEPTH_WORDS(DEPTH_WORDS),
        .WAIT_STATES(WAIT_STATES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .memR      (memR),
        .memW      (memW),
        .mem_ctrl  (mem_ctrl),
        .addr      (addr),
        .dataW     (dataW),
        .resp_valid(resp_valid),
        .dataR     (dataR),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] c);
        case (c[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic is_illegal(input logic r, input logic w, input logic [2:0] c);
        if (r && w) return 1'b1;
        if (c == 3'd3 || c == 3'd6 || c == 3'd7) return 1'b1;
        if (w && c >= 3'd4) return 1'b1;
        return 1'b0;
    endfunction

    // Reference behaviour: byte-addressed memory, little-endian assembly.
    task automatic model_expect(input logic r, input logic w, input logic [2:0] c,
                                input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] exp_data, output logic exp_err,
                                output int exp_lat);
        int n;
        int base;
        logic ill;
        logic mis;
        n        = size_of(c);
        ill      = is_illegal(r, w, c);
        mis      = (r || w) && ((a % n) != 0);
        exp_lat  = WAIT_STATES + 1;
        exp_data = 32'd0;
        exp_err  = ill;
`ifdef MA_MISALIGN_TRAP_EN
        if (mis && !ill) begin
            exp_err = 1'b1;
            exp_lat = 1;
            return;
        end
`else
        if (mis) exp_err = ill;
`endif
        if (ill) return;
        base = int'(a % NBYTES);
        base = base - (base % n);
        if (w) begin
            for (int i = 0; i < n; i++) model[base + i] = d[8*i +: 8];
        end else if (r) begin
            for (int i = 0; i < n; i++) exp_data[8*i +: 8] = model[base + i];
            if (!c[2] && n == 1 && exp_data[7])  exp_data = exp_data | 32'hFFFF_FF00;
            if (!c[2] && n == 2 && exp_data[15]) exp_data = exp_data | 32'hFFFF_0000;
        end
    endtask

    task automatic do_req(input string tag, input logic r, input logic w, input logic [2:0] c,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] got_data, output logic got_err);
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          lat;
        logic        seen;
        logic        ready_bad;
        model_expect(r, w, c, a, d, exp_data, exp_err, exp_lat);
        @(negedge clk);
        check({tag, "_ready_idle"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; memR = r; memW = w; mem_ctrl = c; addr = a; dataW = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        memR = 1'($urandom); memW = 1'($urandom); mem_ctrl = 3'($urandom);
        addr = $urandom; dataW = $urandom;
        lat = 0; seen = 1'b0; ready_bad = 1'b0;
        while (!seen && lat <= 20) begin
            @(negedge clk);
            lat++;
            if (req_ready) ready_bad = 1'b1;
            if (resp_valid) seen = 1'b1;
        end
        got_data = dataR;
        got_err  = err;
        check({tag, "_resp_seen"}, {31'd0, seen}, 32'd1);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busy_ready"}, {31'd0, ready_bad}, 32'd0);
        check({tag, "_data"}, dataR, exp_data);
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        @(negedge clk);
        check({tag, "_resp_drop"}, {29'd0, resp_valid, err, (dataR != 0)}, 32'd0);
    endtask

    logic [31:0] rd;
    logic        re;
    logic [31:0] old_word;
    logic        saw_resp;
    logic        rr;
    logic        rw;

    initial begin
        // Reset held for three cycles
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_dataR", dataR, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) do_req("preload", 1'b0, 1'b1, 3'b010, 32'(i * 4), $urandom, rd, re);

        do_req("sw10", 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, re);
        do_req("lw10", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, rd, re);
        check("lw10_lit", rd, 32'hDEADBEEF);

        do_req("sw20", 1'b0, 1'b1, 3'b010, 32'h20, 32'h0, rd, re);
        do_req("sb23", 1'b0, 1'b1, 3'b000, 32'h23, 32'h80, rd, re);
        do_req("lb23", 1'b1, 1'b0, 3'b000, 32'h23, 32'h0, rd, re);
        check("lb23_lit", rd, 32'hFFFFFF80);
        do_req("lbu23", 1'b1, 1'b0, 3'b100, 32'h23, 32'h0, rd, re);
        check("lbu23_lit", rd, 32'h00000080);
        do_req("lw20", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, rd, re);
        check("lw20_lit", rd, 32'h80000000);

        do_req("sw30", 1'b0, 1'b1, 3'b010, 32'h30, 32'h0, rd, re);
        do_req("sh32", 1'b0, 1'b1, 3'b001, 32'h32, 32'h1234ABCD, rd, re);
        do_req("lh32", 1'b1, 1'b0, 3'b001, 32'h32, 32'h0, rd, re);
        check("lh32_lit", rd, 32'hFFFFABCD);
        do_req("lhu32", 1'b1, 1'b0, 3'b101, 32'h32, 32'h0, rd, re);
        check("lhu32_lit", rd, 32'h0000ABCD);
        do_req("lw30", 1'b1, 1'b0, 3'b010, 32'h30, 32'h0, rd, re);
        check("lw30_lit", rd, 32'hABCD0000);

        do_req("rw_both", 1'b1, 1'b1, 3'b010, 32'h30, 32'hFFFFFFFF, rd, re);
        check("rw_both_err_lit", {31'd0, re}, 32'd1);
        do_req("lw30_after", 1'b1, 1'b0, 3'b010, 32'h30, 32'h0, rd, re);
        check("lw30_after_lit", rd, 32'hABCD0000);

        do_req("sw1004", 1'b0, 1'b1, 3'b010, 32'h1004, 32'hCAFEF00D, rd, re);
        do_req("lw0004", 1'b1, 1'b0, 3'b010, 32'h0004, 32'h0, rd, re);
        check("wrap_lit", rd, 32'hCAFEF00D);

        do_req("sw40", 1'b0, 1'b1, 3'b010, 32'h40, 32'h11223344, rd, re);
        do_req("lw41", 1'b1, 1'b0, 3'b010, 32'h41, 32'h0, rd, re);
`ifdef MA_MISALIGN_TRAP_EN
        check("lw41_lit", {rd[30:0], re}, 32'd1);
`else
        check("lw41_lit", {rd[30:0], re}, {32'h11223344} << 1);
`endif

        do_req("nop", 1'b0, 1'b0, 3'b010, 32'h50, 32'hFFFFFFFF, rd, re);
        check("nop_lit", {rd[30:0], re}, 32'd0);

        // Reset one cycle after a store is accepted
        old_word = {model[32'h53], model[32'h52], model[32'h51], model[32'h50]};
        @(negedge clk);
        req_valid = 1'b1; memR = 1'b0; memW = 1'b1; mem_ctrl = 3'b010;
        addr = 32'h50; dataW = ~old_word;
        @(posedge clk);
        #1;
        req_valid = 1'b0; memW = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        saw_resp = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) saw_resp = 1'b1;
        end
        check("rst_mid_resp", {31'd0, saw_resp}, 32'd0);
        check("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        rst_n = 1'b1;
        do_req("rst_mid_lw", 1'b1, 1'b0, 3'b010, 32'h50, 32'h0, rd, re);
        check("rst_mid_old", rd, old_word);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0:       begin rr = 1'b1; rw = 1'b1; end
                1:       begin rr = 1'b0; rw = 1'b0; end
                2, 3, 4: begin rr = 1'b0; rw = 1'b1; end
                default: begin rr = 1'b1; rw = 1'b0; end
            endcase
            do_req("rand", rr, rw, 3'($urandom_range(0, 7)),
                   32'($urandom_range(0, 127)) | (32'($urandom_range(0, 15)) << 12),
                   $urandom, rd, re);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
